// File: rtl/imem_loader_pkg.sv
// kgprisc_loader_pkg: state encoding and stream framing constants for the instruction memory loader
package kgprisc_loader_pkg;
    localparam logic [2:0] HDR_LO = 3'd0;
    localparam logic [2:0] HDR_HI = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake plus instruction memory write port
interface imem_loader_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian stream bytes into a 32-bit word and flags the final byte
module word_assembler
    import kgprisc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        complete,
    output logic [31:0] word_nxt
);
    logic [1:0]  byte_cnt;
    logic [31:0] word;

    assign complete = shift & (byte_cnt == 2'(BYTES_PER_WORD - 1));

    // current word with the incoming byte merged at its lane, so the final byte is visible the same cycle
    always_comb begin
        word_nxt = word;
        word_nxt[{byte_cnt, 3'b000} +: 8] = byte_in;
    end

    // byte lane counter wraps naturally after the fourth byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (shift) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= word_nxt;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a length-prefixed program into instruction memory, then releases the core
module imem_loader
    import kgprisc_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           reload,
    imem_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           done,
    output logic           err
);
    logic [2:0]      state, nxt;
    logic [15:0]     n;
    logic [ADDR_W:0] index;
    logic [15:0]     hdr;
    logic            xfer, bad, last, complete;
    logic [31:0]     word_nxt;

    assign bus.in_ready = rst & ~reload & (state == HDR_LO || state == HDR_HI || state == DATA);
    assign xfer = bus.in_valid & bus.in_ready;
    assign hdr  = {bus.in_data, n[7:0]};
    assign bad  = (hdr == 16'd0) || (32'(hdr) > 32'(MAX_WORDS));
    assign last = (16'(index) + 16'd1) == n;

    word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (reload),
        .shift    (xfer && state == DATA),
        .byte_in  (bus.in_data),
        .complete (complete),
        .word_nxt (word_nxt)
    );

    // next-state decode; reload overrides everything
    always_comb begin
        nxt = state;
        if (reload) nxt = HDR_LO;
        else begin
            case (state)
                HDR_LO:  nxt = xfer ? HDR_HI : HDR_LO;
                HDR_HI:  nxt = xfer ? (bad ? ERR : DATA) : HDR_HI;
                DATA:    nxt = complete ? WRITE : DATA;
                WRITE:   nxt = last ? RUN : DATA;
                default: nxt = state;
            endcase
        end
    end

    // state, header count and word index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR_LO;
            n     <= '0;
            index <= '0;
        end else begin
            state <= nxt;
            if (reload) begin
                n     <= '0;
                index <= '0;
            end else begin
                if (xfer && state == HDR_LO) n[7:0]  <= bus.in_data;
                if (xfer && state == HDR_HI) n[15:8] <= bus.in_data;
                if (state == WRITE) index <= index + 1'b1;
            end
        end
    end

    // Moore outputs registered from the next state; address and data hold outside WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= nxt == WRITE;
            if (nxt == WRITE) begin
                bus.imem_addr  <= index[ADDR_W-1:0];
                bus.imem_wdata <= word_nxt;
            end
            cpu_rst <= nxt != RUN;
            done    <= nxt == RUN;
            err     <= nxt == ERR;
        end
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the KGPRISC core. It is the writer side of the instruction memory that the core fetches from.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian words. Writes the words into instruction memory.
- Holds the core in reset (cpu_rst) until the full program is stored, then releases it.
- Sits between the host/UART byte source and the core's instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- MAX_WORDS, 1024, largest accepted program length in words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- reload  input  1  single-cycle pulse; aborts or ends the current session and restarts loading.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  active-high reset to the core; 1 while loading or in error.
- done  output  1  program loaded and core running.
- err  output  1  header rejected.

Behaviour:
- Stream format:
  - Byte 0 is count[7:0], byte 1 is count[15:8]. N is the number of words.
  - These are followed by 4N bytes, each word least-significant byte first.
  - Words are written to addresses 0 .. N-1 in order.
- States: HDR_LO, HDR_HI, DATA, WRITE, RUN, ERR.
- While rst is low:
  - state goes to HDR_LO; word index and byte counter are 0.
  - cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0.
- in_ready = rst & ~reload & (state is HDR_LO, HDR_HI or DATA).
  - It is combinational. in_ready never depends on in_valid.
- HDR_LO: on a byte transfer, latch count[7:0] and go to HDR_HI.
- HDR_HI: on a byte transfer, latch count[15:8]. The full 16-bit N is then checked:
  - N == 0 or N > MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: each transfer shifts the byte into position byte_cnt (0..3) of the assembly register. The transfer with byte_cnt == 3 moves to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=index, imem_wdata=assembled word. in_ready=0.
  - Next cycle: index increments. If index+1 == N, go to RUN; otherwise go back to DATA.
  - Minimum cost is 5 cycles per word.
- imem_we, imem_addr and imem_wdata are registered Moore outputs.
  - imem_we is high only in WRITE.
  - imem_addr and imem_wdata hold their last values outside WRITE.
- RUN: cpu_rst=0 and done=1. These are registered, so they change on the first clock edge after the final WRITE. in_ready=0.
- ERR: cpu_rst=1 and err=1. All further bytes are refused (in_ready=0).
- reload (from any state):
  - Next state is HDR_LO. index, byte_cnt, N and the assembly register are cleared.
  - done=0, err=0, cpu_rst=1 on the next edge.
  - Takes priority over any simultaneous byte: in_ready is 0 that cycle, so no byte is consumed.
  - reload in the WRITE cycle: the write on the bus that cycle still completes.
- Bytes arriving with in_valid stalls between them are legal. Gaps of any length are allowed, including inside a word.
- Index arithmetic:
  - index is ADDR_W+1 bits wide, so N == 2**ADDR_W cannot wrap.
  - The comparison with N is unsigned, 16-bit.
- A reset assertion in the middle of a load takes effect immediately (asynchronous). Partially written memory is not cleared.

Decomposition:
- Shared package kgprisc_loader_pkg:
  - state encoding (3-bit enum: HDR_LO, HDR_HI, DATA, WRITE, RUN, ERR)
  - HDR_BYTES=2, BYTES_PER_WORD=4.
- One sub-module, word_assembler:
  - Owns the byte_cnt, the 32-bit shift/position register and the "word complete" flag.
  - Has a clear input driven by reload.
  - imem_loader keeps the FSM, the N/index registers and the output registers.

Test Plan:
- Two-word program:
  - Stimulus: bytes 02 00 | 13 00 10 00 | 33 01 20 00, in_valid held high.
  - Required: writes addr0=0x00100013 and addr1=0x00200133. imem_we pulses exactly twice, 5 cycles apart.
  - Required: cpu_rst falls and done rises one edge after the second WRITE.
- Count zero:
  - Stimulus: header 00 00.
  - Required: err=1, cpu_rst stays 1, in_ready=0, no imem_we.
- Count too large:
  - Stimulus: header 01 04 (N=1025).
  - Required: ERR. A following reload pulse returns to HDR_LO with err=0 and in_ready=1.
- Throttled source:
  - Stimulus: N=1 (header 01 00), in_valid asserted every 3rd cycle, word 0xDEADBEEF sent as EF BE AD DE.
  - Required: single write of 0xDEADBEEF to addr 0; no byte lost or duplicated.
- Abort mid-word:
  - Stimulus: header 02 00, bytes AA BB, then reload coincident with in_valid on byte CC.
  - Required: CC not accepted; state HDR_LO; a new stream 01 00 11 22 33 44 writes 0x44332211 to addr 0.
- Async reset during load:
  - Stimulus: drop rst between bytes of word 1, then release and send a fresh stream.
  - Required: outputs at their reset values immediately; the fresh load completes correctly.
